instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Downstream stage of the program counter: reads currentCount, fetches the instruction word over a
//   valid/ready memory port and hands {instr, instr_pc} to decode with a valid/ready handshake.
//   Computes the next PC (+4 or redirect target) and drives the PC's newCount/write pins.
//   Owns the fetch FSM, in-flight tracking and flush-on-redirect.
// PARAMETERS
//   ADDR_W   32  width of PC / instruction address
//   INSTR_W  32  width of instruction word
//   PC_STEP  4   sequential PC increment (bytes)
// PORTS
//   clk              in   1        single clock; all state updates on posedge
//   reset            in   1        synchronous, active-high
//   pc_in            in   ADDR_W   current PC (from programCounter currentCount)
//   pc_next          out  ADDR_W   next PC value (to programCounter newCount)
//   pc_write         out  1        PC write enable (to programCounter write)
//   redirect_valid   in   1        branch/jump taken this cycle
//   redirect_target  in   ADDR_W   redirect destination
//   imem_req_valid   out  1        memory read request
//   imem_req_addr    out  ADDR_W   request address
//   imem_req_ready   in   1        memory accepts request
//   imem_resp_valid  in   1        read data valid (exactly one per accepted request)
//   imem_resp_data   in   INSTR_W  read data
//   instr_valid      out  1        instruction available to decode
//   instr            out  INSTR_W  fetched instruction
//   instr_pc         out  ADDR_W   address of instr
//   instr_ready      in   1        decode accepts instruction
//   fetch_fault      out  1        misaligned PC detected (sticky)
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 (pc_next=0, instr=0, instr_pc=0); drop flag cleared.
//   States: IDLE, REQ, WAIT, HOLD, FAULT. IDLE->REQ unconditionally on first cycle after reset.
//   REQ: imem_req_valid=1, imem_req_addr=pc_in (combinational). On req_valid&req_ready: latch
//     req_pc<=pc_in, go WAIT. If pc_in[1:0]!=0: no request, go FAULT, fetch_fault<=1.
//   WAIT: on imem_resp_valid: if drop set -> discard data, clear drop, go REQ; else instr<=data,
//     instr_pc<=req_pc, instr_valid<=1, go HOLD, and same cycle pc_write=1, pc_next=req_pc+PC_STEP.
//   HOLD: instr/instr_pc/instr_valid stable until instr_valid&instr_ready; on handshake
//     instr_valid<=0, go REQ (request issued next cycle, so pc_in already updated).
//   Throughput: 1 instr per 3 cycles min with 0-wait memory (REQ, WAIT, HOLD).
//   Redirect (any state except IDLE-reset cycle): pc_write=1, pc_next=redirect_target, overriding
//     sequential +4 the same cycle. Plus per state:
//     REQ w/ handshake same cycle: request issued, drop<=1, go WAIT. REQ w/o handshake: stay REQ.
//     WAIT: drop<=1 (if resp_valid same cycle, that response is discarded, go REQ).
//     HOLD: instr_valid<=0 (decode handshake that cycle is ignored), go REQ.
//     FAULT: fetch_fault<=0, go REQ.
//   FAULT: no requests, pc_write=0 unless redirect; exits only via redirect or reset.
//   Arithmetic: pc_next = req_pc+PC_STEP modulo 2^ADDR_W (32'hFFFFFFFC -> 32'h0), no carry out.
//   pc_write is combinational, high at most one cycle per event; low in all other cycles.
//   At most one request outstanding; imem_req_valid never asserted in WAIT/HOLD/FAULT.
//   Reset mid-operation: returns to IDLE next edge; in-flight response after reset is ignored
//     (IDLE/REQ ignore imem_resp_valid).
// TESTING
//   1. Reset, pc_in=0, mem 0-wait returns 32'h20080005 -> instr_valid with instr_pc=0, pc_write
//      pulse with pc_next=4 in WAIT cycle; instr_ready=1 -> next request at addr 4.
//   2. imem_req_ready low 3 cycles, then resp 2 cycles late -> req_valid/addr held stable,
//      single instr_valid, single pc_write.
//   3. instr_ready low 5 cycles in HOLD -> instr/instr_pc constant, no new request, no pc_write.
//   4. redirect_valid=1, target=32'h00400020 during WAIT -> pc_write/pc_next=32'h00400020 that
//      cycle; arriving response dropped (instr_valid stays 0); next request addr 32'h00400020.
//   5. pc_in=32'h00000006 -> no request, fetch_fault=1 sticky; redirect to 32'h8 clears it, fetches 8.
//   6. pc_in=32'hFFFFFFFC fetch -> pc_next=32'h00000000; reset asserted in WAIT -> IDLE, outputs 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage sitting between the program counter and decode. It reads the
// current PC, issues one read on the instruction memory port, and presents the
// returned word (with its address) to decode using a valid/ready handshake.
// It also computes the next PC (sequential step or redirect target) and drives
// the program counter's write port.
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   reset            synchronous, active-high
//   pc_in            current PC from the program counter
//   pc_next          value to load into the program counter
//   pc_write         program counter write enable (single-cycle pulses)
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  redirect destination
//   imem_req_valid   memory read request
//   imem_req_addr    memory read address
//   imem_req_ready   memory accepts the request
//   imem_resp_valid  memory read data valid (one per accepted request)
//   imem_resp_data   memory read data
//   instr_valid      instruction available to decode
//   instr            fetched instruction word
//   instr_pc         address the instruction was fetched from
//   instr_ready      decode accepts the instruction
//   fetch_fault      sticky flag for a misaligned PC
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               pc_write,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic               fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } FetchState;

    FetchState         state;
    FetchState         nextState;
    logic [ADDR_W-1:0] reqPc;
    logic              dropFlag;
    logic              pcAligned;
    logic              latchReq;
    logic              loadInstr;
    logic              clearValid;
    logic              setDrop;
    logic              clearDrop;
    logic              setFault;
    logic              clearFault;

    // The state register. Reset always lands in IDLE, which spends exactly one
    // cycle there before starting to fetch, so nothing reacts to stale memory
    // traffic or redirects in the cycle right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic plus all combinational outputs. The request and the PC
    // write are combinational so the program counter and memory see them in
    // the same cycle the decision is made. A redirect overrides the sequential
    // PC update in every state except IDLE. The drop flag remembers that the
    // response still in flight belongs to a stale path; when a redirect lands
    // in the very cycle the response arrives, that response is discarded on
    // the spot, so the flag is cleared rather than set (nothing else is
    // outstanding to drop). A misaligned PC never reaches the memory port; if
    // a redirect arrives in that same cycle we simply retry from the target.
    always_comb begin
        nextState      = state;
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        pc_write       = 1'b0;
        pc_next        = '0;
        latchReq       = 1'b0;
        loadInstr      = 1'b0;
        clearValid     = 1'b0;
        setDrop        = 1'b0;
        clearDrop      = 1'b0;
        setFault       = 1'b0;
        clearFault     = 1'b0;
        pcAligned      = (pc_in[1:0] == 2'b00);

        if (!reset) begin
            case (state)
                IDLE: begin
                    nextState = REQ;
                end
                REQ: begin
                    if (pcAligned) begin
                        imem_req_valid = 1'b1;
                        imem_req_addr  = pc_in;
                        if (imem_req_ready) begin
                            latchReq  = 1'b1;
                            nextState = WAIT;
                            if (redirect_valid) begin
                                setDrop = 1'b1;
                            end
                        end
                    end else if (!redirect_valid) begin
                        setFault  = 1'b1;
                        nextState = FAULT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (dropFlag || redirect_valid) begin
                            clearDrop = 1'b1;
                            nextState = REQ;
                        end else begin
                            loadInstr = 1'b1;
                            nextState = HOLD;
                            pc_write  = 1'b1;
                            pc_next   = reqPc + ADDR_W'(PC_STEP);
                        end
                    end else if (redirect_valid) begin
                        setDrop = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        clearValid = 1'b1;
                        nextState  = REQ;
                    end
                end
                FAULT: begin
                    if (redirect_valid) begin
                        clearFault = 1'b1;
                        nextState  = REQ;
                    end
                end
                default: begin
                    nextState = IDLE;
                end
            endcase

            if (redirect_valid && (state != IDLE)) begin
                pc_write = 1'b1;
                pc_next  = redirect_target;
            end
        end
    end

    // Datapath registers. The request PC is captured at the handshake so the
    // instruction carries the address it was actually fetched from, even
    // though the program counter moves on before decode consumes it. The
    // output instruction and its PC stay frozen while decode stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqPc       <= '0;
            dropFlag    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (latchReq) begin
                reqPc <= pc_in;
            end

            if (setDrop) begin
                dropFlag <= 1'b1;
            end else if (clearDrop) begin
                dropFlag <= 1'b0;
            end

            if (loadInstr) begin
                instr       <= imem_resp_data;
                instr_pc    <= reqPc;
                instr_valid <= 1'b1;
            end else if (clearValid) begin
                instr_valid <= 1'b0;
            end

            if (setFault) begin
                fetch_fault <= 1'b1;
            end else if (clearFault) begin
                fetch_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch. It plays the program counter (a register that
// follows pc_write/pc_next), an instruction memory with programmable latency
// and a decode stage with programmable ready. A transaction-level reference
// tracks which PC decode should see next, whether an instruction should be
// waiting, and whether the memory's outstanding read is still useful.
// Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        fetch_fault;

    int total = 0;
    int bad = 0;

    logic [31:0] pcReg = '0;
    logic [31:0] expPc = '0;
    logic [31:0] memAddr = '0;
    logic        memPending = 1'b0;
    logic        memLive = 1'b0;
    logic        validExp = 1'b0;
    logic        staleResp = 1'b0;
    int          memDelay = 0;
    int          nextLatency = 0;
    int          delivered = 0;

    logic        sReqValid;
    logic [31:0] sReqAddr;
    logic        sPcWrite;
    logic [31:0] sPcNext;
    logic        sInstrValid;
    logic [31:0] sInstr;
    logic [31:0] sInstrPc;
    logic        sFault;

    instruction_fetch #(
        .ADDR_W (32),
        .INSTR_W(32),
        .PC_STEP(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_next        (pc_next),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fetch_fault    (fetch_fault)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Memory contents: a scrambled function of the address whose word at
    // address 0 is the 32'h20080005 instruction.
    function automatic logic [31:0] memData(input logic [31:0] addr);
        return (addr * 32'h9E3779B1) ^ 32'h20080005;
    endfunction

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle. Entered just after a falling edge with the control
    // inputs already set by the caller: drives memory response and PC, samples
    // the DUT mid-low-phase, checks it against the reference, then advances
    // the environment and the reference across the rising edge.
    task automatic applyStimulus();
        logic realResp;
        logic liveResp;
        logic acceptReq;
        logic acceptInstr;

        realResp = memPending && (memDelay == 0) && !staleResp;
        if (staleResp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEADBEEF;
        end else begin
            imem_resp_valid = realResp;
            imem_resp_data  = realResp ? memData(memAddr) : 32'h0BAD0BAD;
        end
        pc_in = pcReg;
        #1;
        sReqValid   = imem_req_valid;
        sReqAddr    = imem_req_addr;
        sPcWrite    = pc_write;
        sPcNext     = pc_next;
        sInstrValid = instr_valid;
        sInstr      = instr;
        sInstrPc    = instr_pc;
        sFault      = fetch_fault;

        liveResp    = realResp && memLive && !redirect_valid;
        acceptReq   = imem_req_valid && imem_req_ready;
        acceptInstr = instr_valid && instr_ready && !redirect_valid;

        if (!reset) begin
            checkOutput("pcWrite", 32'(pc_write), 32'(redirect_valid || liveResp));
            if (redirect_valid) begin
                checkOutput("pcNextRedirect", pc_next, redirect_target);
            end else if (liveResp) begin
                checkOutput("pcNextSeq", pc_next, expPc + 32'd4);
            end
            checkOutput("instrValid", 32'(instr_valid), 32'(validExp));
            if (imem_req_valid) begin
                checkOutput("reqAddrPc", imem_req_addr, pcReg);
            end
            if (memPending || validExp) begin
                checkOutput("reqWhileBusy", 32'(imem_req_valid), 0);
            end
            if (pcReg[1:0] != 2'b00) begin
                checkOutput("reqMisaligned", 32'(imem_req_valid), 0);
            end
            if (acceptReq && !redirect_valid) begin
                checkOutput("reqAddrExp", imem_req_addr, expPc);
            end
            if (acceptInstr) begin
                checkOutput("instrPc", instr_pc, expPc);
                checkOutput("instrData", instr, memData(expPc));
                checkOutput("pcAdvanced", pcReg, expPc + 32'd4);
                delivered++;
            end
        end

        @(posedge clk);
        if (reset) begin
            memPending = 1'b0;
            validExp   = 1'b0;
        end else begin
            if (sPcWrite) begin
                pcReg = sPcNext;
            end
            if (realResp) begin
                memPending = 1'b0;
            end else if (memPending && (memDelay > 0)) begin
                memDelay--;
            end
            if (redirect_valid) begin
                memLive  = 1'b0;
                validExp = 1'b0;
                expPc    = redirect_target;
            end else if (liveResp) begin
                validExp = 1'b1;
            end else if (acceptInstr) begin
                validExp = 1'b0;
                expPc    = expPc + 32'd4;
            end
            if (acceptReq) begin
                memPending = 1'b1;
                memAddr    = sReqAddr;
                memDelay   = nextLatency;
                memLive    = !redirect_valid;
            end
        end
        @(negedge clk);
    endtask

    // Two cycles of reset with all handshake inputs idle.
    task automatic doReset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        staleResp      = 1'b0;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
    endtask

    // Load the program counter and the reference with a starting address.
    task automatic setPc(input logic [31:0] value);
        pcReg = value;
        expPc = value;
    endtask

    // Run until decode sees a valid instruction, bounded by a cycle budget.
    task automatic waitInstr(input string tag, output logic found);
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            applyStimulus();
            if (sInstrValid) begin
                found = 1'b1;
            end
        end
        checkOutput(tag, 32'(found), 1);
    endtask

    initial begin
        logic [31:0] rnd;
        logic        found;
        int          writes;
        int          valids;
        int          writeAt;

        $display("[TB] basic fetch from 0 with zero-wait memory");
        doReset();
        setPc(32'h0);
        nextLatency    = 0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        applyStimulus();
        checkOutput("rstReqValid", 32'(sReqValid), 0);
        checkOutput("rstPcWrite", 32'(sPcWrite), 0);
        checkOutput("rstPcNext", sPcNext, 0);
        checkOutput("rstInstrValid", 32'(sInstrValid), 0);
        checkOutput("rstInstr", sInstr, 0);
        checkOutput("rstInstrPc", sInstrPc, 0);
        checkOutput("rstFault", 32'(sFault), 0);
        applyStimulus();
        checkOutput("t1Req", 32'(sReqValid), 1);
        checkOutput("t1ReqAddr", sReqAddr, 32'h0);
        applyStimulus();
        checkOutput("t1PcWrite", 32'(sPcWrite), 1);
        checkOutput("t1PcNext", sPcNext, 32'h4);
        applyStimulus();
        checkOutput("t1Valid", 32'(sInstrValid), 1);
        checkOutput("t1Instr", sInstr, 32'h20080005);
        checkOutput("t1InstrPc", sInstrPc, 32'h0);
        applyStimulus();
        checkOutput("t1NextReq", 32'(sReqValid), 1);
        checkOutput("t1NextAddr", sReqAddr, 32'h4);

        $display("[TB] memory back-pressure and slow response");
        doReset();
        setPc(32'h100);
        nextLatency    = 2;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("t2ReqHeld", 32'(sReqValid), 1);
            checkOutput("t2AddrHeld", sReqAddr, 32'h100);
        end
        imem_req_ready = 1'b1;
        applyStimulus();
        checkOutput("t2Accept", 32'(sReqValid), 1);
        imem_req_ready = 1'b0;
        writes  = 0;
        valids  = 0;
        writeAt = -1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus();
            if (sPcWrite) begin
                writes++;
                writeAt = k;
            end
            if (sInstrValid) begin
                valids++;
            end
        end
        checkOutput("t2Writes", writes, 1);
        checkOutput("t2WriteAt", writeAt, 3);
        checkOutput("t2Valids", valids, 1);

        $display("[TB] decode stall in HOLD");
        doReset();
        setPc(32'h200);
        nextLatency    = 0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        applyStimulus();
        applyStimulus();
        imem_req_ready = 1'b0;
        applyStimulus();
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("t3Valid", 32'(sInstrValid), 1);
            checkOutput("t3Instr", sInstr, memData(32'h200));
            checkOutput("t3InstrPc", sInstrPc, 32'h200);
            checkOutput("t3NoReq", 32'(sReqValid), 0);
            checkOutput("t3NoWrite", 32'(sPcWrite), 0);
        end
        instr_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("t3NextReq", 32'(sReqValid), 1);
        checkOutput("t3NextAddr", sReqAddr, 32'h204);
        checkOutput("t3ValidDrop", 32'(sInstrValid), 0);

        $display("[TB] redirect while waiting on memory");
        doReset();
        setPc(32'h300);
        nextLatency    = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        applyStimulus();
        applyStimulus();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h00400020;
        applyStimulus();
        checkOutput("t4PcWrite", 32'(sPcWrite), 1);
        checkOutput("t4PcNext", sPcNext, 32'h00400020);
        redirect_valid = 1'b0;
        applyStimulus();
        checkOutput("t4DropWrite", 32'(sPcWrite), 0);
        applyStimulus();
        checkOutput("t4DropValid", 32'(sInstrValid), 0);
        checkOutput("t4Req", 32'(sReqValid), 1);
        checkOutput("t4ReqAddr", sReqAddr, 32'h00400020);
        imem_req_ready = 1'b1;
        nextLatency    = 0;
        waitInstr("t4Deliver", found);
        checkOutput("t4InstrPc", sInstrPc, 32'h00400020);
        checkOutput("t4Instr", sInstr, memData(32'h00400020));

        $display("[TB] misaligned PC and recovery");
        doReset();
        setPc(32'h6);
        nextLatency    = 0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("t5NoReq", 32'(sReqValid), 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput("t5Fault", 32'(sFault), 1);
            checkOutput("t5FaultNoReq", 32'(sReqValid), 0);
            checkOutput("t5FaultNoWrite", 32'(sPcWrite), 0);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h8;
        applyStimulus();
        checkOutput("t5PcWrite", 32'(sPcWrite), 1);
        checkOutput("t5PcNext", sPcNext, 32'h8);
        redirect_valid = 1'b0;
        applyStimulus();
        checkOutput("t5FaultClear", 32'(sFault), 0);
        checkOutput("t5Req", 32'(sReqValid), 1);
        checkOutput("t5ReqAddr", sReqAddr, 32'h8);
        waitInstr("t5Deliver", found);
        checkOutput("t5InstrPc", sInstrPc, 32'h8);

        $display("[TB] PC wrap and reset in WAIT");
        doReset();
        setPc(32'hFFFFFFFC);
        nextLatency    = 0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t6PcWrite", 32'(sPcWrite), 1);
        checkOutput("t6PcWrap", sPcNext, 32'h0);
        nextLatency = 3;
        applyStimulus();
        checkOutput("t6Valid", 32'(sInstrValid), 1);
        checkOutput("t6InstrPc", sInstrPc, 32'hFFFFFFFC);
        applyStimulus();
        checkOutput("t6Req", 32'(sReqValid), 1);
        checkOutput("t6ReqAddr", sReqAddr, 32'h0);
        imem_req_ready = 1'b0;
        reset = 1'b1;
        applyStimulus();
        reset     = 1'b0;
        staleResp = 1'b1;
        applyStimulus();
        checkOutput("t6RstInstr", sInstr, 0);
        checkOutput("t6RstInstrPc", sInstrPc, 0);
        checkOutput("t6RstValid", 32'(sInstrValid), 0);
        checkOutput("t6RstReq", 32'(sReqValid), 0);
        checkOutput("t6RstWrite", 32'(sPcWrite), 0);
        checkOutput("t6RstFault", 32'(sFault), 0);
        applyStimulus();
        checkOutput("t6StaleWrite", 32'(sPcWrite), 0);
        staleResp = 1'b0;
        applyStimulus();
        checkOutput("t6StaleValid", 32'(sInstrValid), 0);
        imem_req_ready = 1'b1;
        nextLatency    = 0;
        waitInstr("t6Deliver", found);
        checkOutput("t6NewInstrPc", sInstrPc, 32'h0);
        checkOutput("t6NewInstr", sInstr, 32'h20080005);

        $display("[TB] randomized traffic with redirects");
        doReset();
        setPc(32'h1000);
        delivered = 0;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready  = ($urandom_range(0, 3) != 0);
            instr_ready     = ($urandom_range(0, 2) != 0);
            nextLatency     = int'($urandom_range(0, 3));
            rnd             = $urandom;
            redirect_valid  = (i >= 1) && ($urandom_range(0, 24) == 0);
            redirect_target = {rnd[31:2], 2'b00};
            applyStimulus();
        end
        redirect_valid = 1'b0;
        checkOutput("randomProgress", 32'(delivered > 50), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
